// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg
// Shared definitions for the branch hazard controller: operating-mode
// encodings, the stall-mode state enum and the legal resolve-latency range.
package branch_hazard_ctrl_pkg;

    // Operating modes
    localparam int MODE_STALL = 0;  // hold fetch until the branch resolves
    localparam int MODE_PNT   = 1;  // predict not-taken, flush on taken

    // Legal range of the ID-to-outcome latency
    localparam int RESOLVE_LAT_MIN = 1;
    localparam int RESOLVE_LAT_MAX = 7;

    // Width of the stall-mode countdown, wide enough for RESOLVE_LAT_MAX
    localparam int LAT_CNT_W = $clog2(RESOLVE_LAT_MAX + 1);

    // Stall-mode controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } bhc_state_e;

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for the performance statistics.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high clear
//   inc_i    add one this cycle (ignored once the counter is all ones)
//   count_o  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
// Tracks branches decoded in ID until their outcome is known RESOLVE_LAT
// cycles later and drives PC hold, pipeline flushes and PC redirect.
// MODE_STALL holds fetch until resolution; MODE_PNT keeps fetching down the
// not-taken path and squashes it when a branch turns out taken.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   brID           branch-type decodes in ID (any set bit = one branch)
//   stall_in       external pipeline stall, freezes this block
//   branch_taken   outcome of the oldest pending branch in its resolve cycle
//   PChold         hold the PC
//   IFIDflush      bubble into IF/ID
//   IDEXflush      bubble into ID/EX
//   redirect       PC loads the branch target this cycle
//   stall_cnt      saturating count of PChold cycles
//   mispred_cnt    saturating count of taken branches in MODE_PNT
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int NUM_BR      = 2,
    parameter int RESOLVE_LAT = 1,
    parameter int MODE        = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_BR-1:0] brID,
    input  logic              stall_in,
    input  logic              branch_taken,
    output logic              PChold,
    output logic              IFIDflush,
    output logic              IDEXflush,
    output logic              redirect,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    logic                   det;
    logic                   resolve;
    logic                   taken_res;
    logic                   wait_done;
    logic                   load;
    logic                   mispred_inc;
    logic [RESOLVE_LAT-1:0] pend_q, pend_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    bhc_state_e             state_q, state_d;

    assign det       = (|brID) & ~stall_in;
    assign resolve   = pend_q[RESOLVE_LAT-1] & ~stall_in;
    assign taken_res = resolve & branch_taken;

    // In stall mode the countdown and the pending shift register track the
    // same single branch; resolution needs both to agree.
    assign wait_done = (state_q == ST_WAIT) &&
                       (cnt_q == LAT_CNT_W'(RESOLVE_LAT_MIN)) && resolve;

    // Stall mode accepts a new branch only from IDLE. Predict-not-taken
    // drops a branch detected in the same cycle a taken one resolves: it
    // is younger and therefore on the wrong path.
    assign load = (MODE == MODE_STALL) ? (det && (state_q == ST_IDLE))
                                       : (det && !taken_res);

    always_comb begin
        pend_d = pend_q;
        if (!stall_in) begin
            if ((MODE == MODE_PNT) && taken_res) begin
                pend_d = '0;
            end else begin
                pend_d = (pend_q << 1) | RESOLVE_LAT'(load);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if ((MODE == MODE_STALL) && !stall_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (det) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT_W'(RESOLVE_LAT);
                    end
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                    if (wait_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // PChold depends only on state and the ID decode, never on branch_taken.
    always_comb begin
        PChold    = 1'b0;
        IFIDflush = 1'b0;
        IDEXflush = 1'b0;
        redirect  = 1'b0;
        if (MODE == MODE_STALL) begin
            PChold    = ((state_q == ST_IDLE) && det) ||
                        ((state_q == ST_WAIT) && !wait_done);
            IFIDflush = PChold && !stall_in;
            redirect  = wait_done && branch_taken;
        end else begin
            IFIDflush = taken_res;
            IDEXflush = taken_res;
            redirect  = taken_res;
        end
    end

    assign mispred_inc = (MODE == MODE_PNT) && taken_res;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (PChold),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (mispred_inc),
        .count_o (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl
// Directed vectors against four configurations of branch_hazard_ctrl:
//   a: MODE 0, RESOLVE_LAT 1     b: MODE 0, RESOLVE_LAT 3
//   c: MODE 1, RESOLVE_LAT 2     d: MODE 1, RESOLVE_LAT 1, CNT_W 2
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 4 time units after the edge.
module tb_branch_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0] br_a, br_b, br_c, br_d;
    logic st_a, st_b, st_c, st_d;
    logic tk_a, tk_b, tk_c, tk_d;
    logic ph_a, ph_b, ph_c, ph_d;
    logic fi_a, fi_b, fi_c, fi_d;
    logic fe_a, fe_b, fe_c, fe_d;
    logic rd_a, rd_b, rd_c, rd_d;
    logic [15:0] sc_a, sc_b, sc_c, mc_a, mc_b, mc_c;
    logic [1:0]  sc_d, mc_d;

    branch_hazard_ctrl #(.NUM_BR(2), .RESOLVE_LAT(1), .MODE(0), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .brID(br_a), .stall_in(st_a), .branch_taken(tk_a),
        .PChold(ph_a), .IFIDflush(fi_a), .IDEXflush(fe_a), .redirect(rd_a),
        .stall_cnt(sc_a), .mispred_cnt(mc_a));

    branch_hazard_ctrl #(.NUM_BR(2), .RESOLVE_LAT(3), .MODE(0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .brID(br_b), .stall_in(st_b), .branch_taken(tk_b),
        .PChold(ph_b), .IFIDflush(fi_b), .IDEXflush(fe_b), .redirect(rd_b),
        .stall_cnt(sc_b), .mispred_cnt(mc_b));

    branch_hazard_ctrl #(.NUM_BR(2), .RESOLVE_LAT(2), .MODE(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .brID(br_c), .stall_in(st_c), .branch_taken(tk_c),
        .PChold(ph_c), .IFIDflush(fi_c), .IDEXflush(fe_c), .redirect(rd_c),
        .stall_cnt(sc_c), .mispred_cnt(mc_c));

    branch_hazard_ctrl #(.NUM_BR(2), .RESOLVE_LAT(1), .MODE(1), .CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .brID(br_d), .stall_in(st_d), .branch_taken(tk_d),
        .PChold(ph_d), .IFIDflush(fi_d), .IDEXflush(fe_d), .redirect(rd_d),
        .stall_cnt(sc_d), .mispred_cnt(mc_d));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clr_inputs();
        br_a = '0; br_b = '0; br_c = '0; br_d = '0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; st_d = 1'b0;
        tk_a = 1'b0; tk_b = 1'b0; tk_c = 1'b0; tk_d = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        clr_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        do_reset();
        look();
        // Reset state
        check("rst a PChold", ph_a, 0);
        check("rst a IFIDflush", fi_a, 0);
        check("rst b redirect", rd_b, 0);
        check("rst c IDEXflush", fe_c, 0);
        check("rst a stall_cnt", sc_a, 0);
        check("rst c mispred_cnt", mc_c, 0);

        // MODE 0, LAT 1: branch at t, taken at t+1
        cyc(); br_a = 2'b01; look();
        check("m0l1 t PChold", ph_a, 1);
        check("m0l1 t IFIDflush", fi_a, 1);
        check("m0l1 t redirect", rd_a, 0);
        cyc(); br_a = 2'b00; tk_a = 1'b1; look();
        check("m0l1 t+1 PChold", ph_a, 0);
        check("m0l1 t+1 redirect", rd_a, 1);
        check("m0l1 t+1 IFIDflush", fi_a, 0);
        cyc(); tk_a = 1'b0; look();
        check("m0l1 t+2 redirect", rd_a, 0);
        check("m0l1 stall_cnt", sc_a, 1);
        // Two decode bits set is a single branch, resolved not-taken
        cyc(); br_a = 2'b11; look();
        check("m0l1 multi PChold", ph_a, 1);
        cyc(); br_a = 2'b00; look();
        check("m0l1 multi res PChold", ph_a, 0);
        check("m0l1 multi res redirect", rd_a, 0);
        cyc(); look();
        check("m0l1 multi stall_cnt", sc_a, 2);

        // MODE 0, LAT 3 with a one-cycle external stall at t+1
        do_reset();
        cyc(); br_b = 2'b10; look();
        check("m0l3 t PChold", ph_b, 1);
        cyc(); br_b = 2'b00; st_b = 1'b1; look();
        check("m0l3 t+1 PChold", ph_b, 1);
        check("m0l3 t+1 IFIDflush", fi_b, 0);
        cyc(); st_b = 1'b0; look();
        check("m0l3 t+2 PChold", ph_b, 1);
        check("m0l3 t+2 IFIDflush", fi_b, 1);
        cyc(); tk_b = 1'b1; look();
        check("m0l3 t+3 PChold", ph_b, 1);
        check("m0l3 t+3 redirect", rd_b, 0);
        cyc(); look();
        check("m0l3 t+4 PChold", ph_b, 0);
        check("m0l3 t+4 redirect", rd_b, 1);
        cyc(); tk_b = 1'b0; look();
        check("m0l3 t+5 redirect", rd_b, 0);
        check("m0l3 stall_cnt", sc_b, 4);

        // MODE 1, LAT 2: branches at t and t+1, first taken at t+2
        do_reset();
        cyc(); br_c = 2'b01; look();
        check("m1 t PChold", ph_c, 0);
        check("m1 t IFIDflush", fi_c, 0);
        cyc(); look();
        check("m1 t+1 redirect", rd_c, 0);
        cyc(); br_c = 2'b00; tk_c = 1'b1; look();
        check("m1 t+2 redirect", rd_c, 1);
        check("m1 t+2 IFIDflush", fi_c, 1);
        check("m1 t+2 IDEXflush", fe_c, 1);
        cyc(); look();
        check("m1 t+3 redirect", rd_c, 0);
        cyc(); look();
        check("m1 t+4 IDEXflush", fe_c, 0);
        check("m1 mispred_cnt", mc_c, 1);
        check("m1 stall_cnt", sc_c, 0);

        // MODE 1: branch detected in a taken-resolution cycle is squashed
        do_reset();
        cyc(); br_c = 2'b10; look();
        cyc(); br_c = 2'b00; look();
        cyc(); br_c = 2'b01; tk_c = 1'b1; look();
        check("m1 sq res redirect", rd_c, 1);
        cyc(); br_c = 2'b00; look();
        check("m1 sq t+1 redirect", rd_c, 0);
        cyc(); look();
        check("m1 sq t+2 redirect", rd_c, 0);
        check("m1 sq mispred_cnt", mc_c, 1);

        // MODE 1: two not-taken branches back to back
        do_reset();
        cyc(); br_c = 2'b10; look();
        cyc(); look();
        cyc(); br_c = 2'b00; look();
        check("m1 nt first redirect", rd_c, 0);
        check("m1 nt first IFIDflush", fi_c, 0);
        cyc(); look();
        check("m1 nt second redirect", rd_c, 0);
        check("m1 nt second IDEXflush", fe_c, 0);
        cyc(); look();
        check("m1 nt mispred_cnt", mc_c, 0);
        check("m1 nt stall_cnt", sc_c, 0);

        // MODE 0, LAT 3: reset during WAIT abandons the branch
        do_reset();
        cyc(); br_b = 2'b01; look();
        check("rstw t PChold", ph_b, 1);
        cyc(); br_b = 2'b00; rst = 1'b1; look();
        cyc(); rst = 1'b0; tk_b = 1'b1; look();
        check("rstw t+2 PChold", ph_b, 0);
        check("rstw t+2 IFIDflush", fi_b, 0);
        check("rstw t+2 redirect", rd_b, 0);
        check("rstw t+2 stall_cnt", sc_b, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); look();
            check("rstw later redirect", rd_b, 0);
        end
        tk_b = 1'b0;

        // MODE 1, CNT_W 2: five taken mispredicts saturate at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(); br_d = 2'b01; tk_d = 1'b0; look();
            check("sat mispred_cnt", mc_d, (i < 3) ? i : 3);
            cyc(); br_d = 2'b00; tk_d = 1'b1; look();
            check("sat redirect", rd_d, 1);
        end
        cyc(); tk_d = 1'b0; look();
        check("sat final mispred_cnt", mc_d, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
